// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep stereo holding register, ws master, MSB-first sdout with one-bit delay.
// Latency: a pair accepted before a frame boundary appears from the next left slot; sdout bit 1 is the MSB.
// Backpressure: in_rdy is low while a pair is held, except in the cycle whose edge loads the shift registers.
module i2s_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int SLOT_WIDTH = 16
) (
    input  logic                  sck,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ldata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic                  ws,
    output logic                  sdout,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] DW_BITS  = BW'(DATA_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic                  ch;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] sh_l;
    logic [DATA_WIDTH-1:0] sh_r;
    logic                  slot_end;
    logic                  frame_end;
    logic                  load;
    logic                  accept;

    assign slot_end  = (bit_cnt == LAST_BIT);
    assign frame_end = (state == RUN) && ch && slot_end;
    // The edge ending this cycle moves the outputs to left-slot bit 0.
    assign load      = en && ((state == IDLE) || frame_end);
    assign in_rdy    = ~hold_vld | load;
    assign accept    = in_vld & in_rdy;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= 1'b0;
            bit_cnt     <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            hold_vld    <= 1'b0;
            sh_l        <= '0;
            sh_r        <= '0;
            ws          <= 1'b0;
            sdout       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept) begin
                hold_l   <= ldata;
                hold_r   <= rdata;
                hold_vld <= 1'b1;
            end else if (load) begin
                hold_vld <= 1'b0;
            end

            if (load) begin
                state       <= RUN;
                ch          <= 1'b0;
                bit_cnt     <= '0;
                ws          <= 1'b0;
                sdout       <= 1'b0;
                frame_start <= 1'b1;
                underrun    <= ~hold_vld;
                sh_l        <= hold_vld ? hold_l : '0;
                sh_r        <= hold_vld ? hold_r : '0;
            end else if (state == RUN) begin
                if (frame_end) begin
                    state   <= IDLE;
                    ch      <= 1'b0;
                    bit_cnt <= '0;
                    ws      <= 1'b0;
                    sdout   <= 1'b0;
                end else if (slot_end) begin
                    ch      <= 1'b1;
                    bit_cnt <= '0;
                    ws      <= 1'b1;
                    sdout   <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    // Next bit index lies in 1..DATA_WIDTH: emit the channel MSB and shift.
                    if (bit_cnt < DW_BITS) begin
                        if (ch) begin
                            sdout <= sh_r[DATA_WIDTH-1];
                            sh_r  <= sh_r << 1;
                        end else begin
                            sdout <= sh_l[DATA_WIDTH-1];
                            sh_l  <= sh_l << 1;
                        end
                    end else begin
                        sdout <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (DATA_WIDTH=8, SLOT_WIDTH=16) with hand-computed slot bit patterns.
module tb_i2s_tx;

    logic       sck;
    logic       rst_n;
    logic       en;
    logic [7:0] ldata;
    logic [7:0] rdata;
    logic       in_vld;
    logic       in_rdy;
    logic       ws;
    logic       sdout;
    logic       frame_start;
    logic       underrun;

    int vecs = 0;
    int errs = 0;

    // Streaming source: advances to the next pair after each accepted transfer.
    logic [7:0] src_l [0:4];
    logic [7:0] src_r [0:4];
    int         sidx   = 0;
    logic       stream = 1'b0;

    i2s_tx #(.DATA_WIDTH(8), .SLOT_WIDTH(16)) dut (
        .sck        (sck),
        .rst_n      (rst_n),
        .en         (en),
        .ldata      (ldata),
        .rdata      (rdata),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .ws         (ws),
        .sdout      (sdout),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic xfer;
        xfer = in_vld && in_rdy;
        @(posedge sck);
        #1;
        if (xfer && stream && sidx < 4) begin
            sidx++;
            ldata = src_l[sidx];
            rdata = src_r[sidx];
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_rdy);
        chk({tag, " ws"}, ws, 1'b0);
        chk({tag, " sdout"}, sdout, 1'b0);
        chk({tag, " frame_start"}, frame_start, 1'b0);
        chk({tag, " underrun"}, underrun, 1'b0);
        chk({tag, " in_rdy"}, in_rdy, exp_rdy);
    endtask

    // Entered with the outputs at left-slot bit 0. lpat/rpat list the 16 slot bits, first bit at [15].
    task automatic frame(input string tag, input logic [15:0] lpat, input logic [15:0] rpat,
                         input logic exp_under, input logic exp_rdy_mid,
                         input int drop_at, input int rst_at);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s ws k=%0d", tag, k), ws, (k >= 16));
            chk($sformatf("%s sdout k=%0d", tag, k), sdout, (k < 16) ? lpat[15-k] : rpat[31-k]);
            chk($sformatf("%s frame_start k=%0d", tag, k), frame_start, (k == 0));
            chk($sformatf("%s underrun k=%0d", tag, k), underrun, (k == 0) && exp_under);
            chk($sformatf("%s in_rdy k=%0d", tag, k), in_rdy, (k == 31 && en) ? 1'b1 : exp_rdy_mid);
            if (k == drop_at) en = 1'b0;
            if (k == rst_at) begin
                rst_n = 1'b0;
                en    = 1'b0;
                #1;
                chk_idle({tag, " async reset"}, 1'b1);
                return;
            end
            tick();
        end
    endtask

    initial begin
        src_l[0] = 8'h81; src_r[0] = 8'h42;
        src_l[1] = 8'hF0; src_r[1] = 8'h0F;
        src_l[2] = 8'hC3; src_r[2] = 8'h96;
        src_l[3] = 8'h5A; src_r[3] = 8'hE7;
        src_l[4] = 8'h11; src_r[4] = 8'h22;

        // Reset and idle with en=0
        rst_n = 1'b0; en = 1'b0; in_vld = 1'b0; ldata = 8'h00; rdata = 8'h00;
        #1;
        chk_idle("reset", 1'b1);
        @(posedge sck); @(posedge sck); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("idle en0", 1'b1);
        end

        // Single pair A5/3C, then an underrun frame, then stop mid-frame
        ldata = 8'hA5; rdata = 8'h3C; in_vld = 1'b1;
        tick();
        in_vld = 1'b0; ldata = 8'h00; rdata = 8'h00;
        chk("held in_rdy", in_rdy, 1'b0);
        en = 1'b1; #1;
        chk("load in_rdy", in_rdy, 1'b1);
        tick();
        frame("A5_3C", 16'h5280, 16'h1E00, 1'b0, 1'b1, -1, -1);
        frame("underrun", 16'h0000, 16'h0000, 1'b1, 1'b1, 10, -1);
        chk_idle("after underrun frame", 1'b1);

        // Continuous stream; en dropped at L bit 5 of the third frame
        stream = 1'b1; sidx = 0;
        ldata = src_l[0]; rdata = src_r[0]; in_vld = 1'b1;
        tick();
        chk("stream held in_rdy", in_rdy, 1'b0);
        en = 1'b1; #1;
        chk("stream load in_rdy", in_rdy, 1'b1);
        tick();
        frame("81_42", 16'h4080, 16'h2100, 1'b0, 1'b0, -1, -1);
        frame("F0_0F", 16'h7800, 16'h0780, 1'b0, 1'b0, -1, -1);
        frame("C3_96", 16'h6180, 16'h4B00, 1'b0, 1'b0, 5, -1);
        for (int i = 0; i < 3; i++) begin
            chk_idle("stopped", 1'b0);
            tick();
        end

        // Held pair survives IDLE; reset at R bit 4
        stream = 1'b0; in_vld = 1'b0;
        en = 1'b1; #1;
        chk("restart in_rdy", in_rdy, 1'b1);
        tick();
        frame("5A_E7", 16'h2D00, 16'h7380, 1'b0, 1'b1, -1, 20);
        tick();
        chk_idle("in reset", 1'b1);
        rst_n = 1'b1;
        tick();
        chk_idle("post reset", 1'b1);

        // Fresh push after reset
        ldata = 8'hA5; rdata = 8'h3C; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        en = 1'b1;
        tick();
        frame("A5_3C again", 16'h5280, 16'h1E00, 1'b0, 1'b1, 0, -1);
        chk_idle("final idle", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
